// File: rtl/ej32_boot_loader.sv
// -----------------------------------------------------------------------------
// ej32_boot_loader
//
// Streams a ROM image of ROM_SZ bytes into eJ32 memory while holding the core
// in reset. The core is released once the last byte has been written and a
// settle period of ROM_WAIT cycles has passed.
//
// Flow: IDLE --start--> LOAD --last byte--> SETTLE --ROM_WAIT--> RUN
// RUN is left only through rst.
//
// Parameters
//   MEM0     : memory byte address of the first image byte
//   ROM_SZ   : image size in bytes (1..65535)
//   ROM_WAIT : settle cycles between the final write and core release
//
// Ports
//   clk      : single clock, all state changes on its rising edge
//   rst      : synchronous active-high reset
//   start    : begins a load when in IDLE (ignored elsewhere)
//   s_valid  : s_data carries a valid image byte
//   s_data   : image byte stream, ascending address order
//   s_ready  : loader accepts s_data this cycle (LOAD only)
//   mem_we   : byte write strobe, one cycle after each accepted byte
//   mem_ai   : byte write address (MEM0 + byte index, 16-bit wrap)
//   mem_vi   : byte write data
//   cpu_rst  : holds the eJ32 core in reset while high
//   busy     : high in LOAD and SETTLE
//   done     : high in RUN
//   cnt      : number of bytes accepted so far
//   sum8     : modulo-256 sum of accepted bytes
// -----------------------------------------------------------------------------
module ej32_boot_loader #(
  parameter logic [15:0] MEM0     = 16'h0000,
  parameter int unsigned ROM_SZ   = 8192,
  parameter int unsigned ROM_WAIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  output logic        s_ready,
  output logic        mem_we,
  output logic [15:0] mem_ai,
  output logic [7:0]  mem_vi,
  output logic        cpu_rst,
  output logic        busy,
  output logic        done,
  output logic [15:0] cnt,
  output logic [7:0]  sum8
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_RUN    = 2'd3
  } state_e;

  // Settle counter only needs to reach ROM_WAIT; keep at least one bit so
  // ROM_WAIT=0 still elaborates cleanly.
  localparam int unsigned    WAIT_W    = (ROM_WAIT > 0) ? $clog2(ROM_WAIT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ROM_WAIT);
  // One extra bit so the compare against ROM_SZ cannot alias on wrap.
  localparam logic [16:0]    LAST_CNT  = 17'(ROM_SZ);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q,  wait_d;
  logic [15:0]       cnt_q,   cnt_d;
  logic [7:0]        sum_q,   sum_d;
  logic              we_q,    we_d;
  logic [15:0]       ai_q,    ai_d;
  logic [7:0]        vi_q,    vi_d;

  logic handshake;
  logic last_byte;

  // s_ready is a pure decode of LOAD, so the handshake only needs s_valid.
  assign handshake = s_valid && (state_q == ST_LOAD);
  assign last_byte = handshake && (({1'b0, cnt_q} + 17'd1) == LAST_CNT);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    wait_d  = wait_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // No timeout: a gap in s_valid simply holds here.
        if (last_byte) begin
          state_d = ST_SETTLE;
          wait_d  = '0;
        end
      end
      ST_SETTLE: begin
        // The first SETTLE cycle carries the final mem_we pulse; the count
        // of ROM_WAIT cycles starts after it, so RUN follows ROM_WAIT+1
        // cycles after the transition into SETTLE.
        if (wait_q == WAIT_LAST) begin
          state_d = ST_RUN;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: write port, byte counter and checksum
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d = cnt_q;
    sum_d = sum_q;
    we_d  = 1'b0;
    ai_d  = ai_q;   // address and data hold their last values between writes
    vi_d  = vi_q;

    if (handshake) begin
      we_d  = 1'b1;
      ai_d  = MEM0 + cnt_q;     // 16-bit wrap is intended
      vi_d  = s_data;
      cnt_d = cnt_q + 16'd1;
      sum_d = sum_q + s_data;   // modulo-256 by width
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      we_q    <= 1'b0;
      ai_q    <= '0;
      vi_q    <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      we_q    <= we_d;
      ai_q    <= ai_d;
      vi_q    <= vi_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: status flags decode straight from the state register, so
  // cpu_rst falls in exactly the cycle done rises.
  // ---------------------------------------------------------------------------
  assign s_ready = (state_q == ST_LOAD);
  assign busy    = (state_q == ST_LOAD) || (state_q == ST_SETTLE);
  assign done    = (state_q == ST_RUN);
  assign cpu_rst = (state_q != ST_RUN);
  assign mem_we  = we_q;
  assign mem_ai  = ai_q;
  assign mem_vi  = vi_q;
  assign cnt     = cnt_q;
  assign sum8    = sum_q;

endmodule

// File: tb/tb_ej32_boot_loader.sv
// -----------------------------------------------------------------------------
// tb_ej32_boot_loader
//
// Three loaders share one stimulus stream:
//   d0 : MEM0=0000, ROM_SZ=16, ROM_WAIT=3
//   d1 : MEM0=FFF8, ROM_SZ=16, ROM_WAIT=3  (address wrap)
//   d2 : MEM0=0000, ROM_SZ=16, ROM_WAIT=0  (no settle count)
// A behavioural model (bytes accepted, running sum, release cycle) predicts
// every output each cycle; literal expectations pin the model.
// -----------------------------------------------------------------------------
module tb_ej32_boot_loader;

  localparam int N   = 3;
  localparam int ROM = 16;
  localparam logic [15:0] P_MEM0 [N] = '{16'h0000, 16'hFFF8, 16'h0000};
  localparam int          P_WAIT [N] = '{3, 3, 0};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;

  logic        rdy  [N];
  logic        we   [N];
  logic [15:0] ai   [N];
  logic [7:0]  vi   [N];
  logic        crst [N];
  logic        bsy  [N];
  logic        dn   [N];
  logic [15:0] cn   [N];
  logic [7:0]  sm   [N];

  always #5 clk = ~clk;

  ej32_boot_loader #(.MEM0(16'h0000), .ROM_SZ(16), .ROM_WAIT(3)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(rdy[0]), .mem_we(we[0]), .mem_ai(ai[0]), .mem_vi(vi[0]),
    .cpu_rst(crst[0]), .busy(bsy[0]), .done(dn[0]), .cnt(cn[0]), .sum8(sm[0]));

  ej32_boot_loader #(.MEM0(16'hFFF8), .ROM_SZ(16), .ROM_WAIT(3)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(rdy[1]), .mem_we(we[1]), .mem_ai(ai[1]), .mem_vi(vi[1]),
    .cpu_rst(crst[1]), .busy(bsy[1]), .done(dn[1]), .cnt(cn[1]), .sum8(sm[1]));

  ej32_boot_loader #(.MEM0(16'h0000), .ROM_SZ(16), .ROM_WAIT(0)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .s_valid(s_valid), .s_data(s_data),
    .s_ready(rdy[2]), .mem_we(we[2]), .mem_ai(ai[2]), .mem_vi(vi[2]),
    .cpu_rst(crst[2]), .busy(bsy[2]), .done(dn[2]), .cnt(cn[2]), .sum8(sm[2]));

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit cmp_en  = 1'b0;

  logic [7:0] img [64];

  // Model: has a start been taken, bytes accepted, sum, expected write port,
  // and the cycle in which the core must be released (-1 = not yet known).
  bit          m_started [N];
  int          m_cnt     [N];
  logic [7:0]  m_sum     [N];
  bit          m_we      [N];
  logic [15:0] m_ai      [N];
  logic [7:0]  m_vi      [N];
  int          m_rel     [N];

  // Observed write log and timing, for literal checks.
  logic [15:0] wlog     [N][64];
  int          wn       [N];
  int          last_we  [N];
  int          done_cyc [N];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_logs();
    for (int i = 0; i < N; i++) begin
      wn[i]       = 0;
      last_we[i]  = -1;
      done_cyc[i] = -1;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model update on each rising edge, from pre-edge inputs
  // ---------------------------------------------------------------------------
  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        m_started[i] = 1'b0;
        m_cnt[i]     = 0;
        m_sum[i]     = 8'h00;
        m_we[i]      = 1'b0;
        m_ai[i]      = 16'h0000;
        m_vi[i]      = 8'h00;
        m_rel[i]     = -1;
      end else begin
        m_we[i] = 1'b0;
        if (!m_started[i]) begin
          if (start) m_started[i] = 1'b1;
        end else if (m_cnt[i] < ROM && s_valid) begin
          m_we[i]  = 1'b1;
          m_ai[i]  = P_MEM0[i] + 16'(m_cnt[i]);
          m_vi[i]  = s_data;
          m_cnt[i] = m_cnt[i] + 1;
          m_sum[i] = m_sum[i] + s_data;
          // Final write shows in this cycle; release ROM_WAIT+1 cycles later.
          if (m_cnt[i] == ROM) m_rel[i] = cyc + P_WAIT[i] + 1;
        end
      end
    end
    cmp_en = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Compare process: every output of every loader, every cycle
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < N; i++) begin
        logic exp_done;
        exp_done = (m_rel[i] >= 0) && (cyc >= m_rel[i]);
        check($sformatf("d%0d.s_ready", i), rdy[i], m_started[i] && (m_cnt[i] < ROM));
        check($sformatf("d%0d.mem_we",  i), we[i],  m_we[i]);
        check($sformatf("d%0d.mem_ai",  i), ai[i],  m_ai[i]);
        check($sformatf("d%0d.mem_vi",  i), vi[i],  m_vi[i]);
        check($sformatf("d%0d.cnt",     i), cn[i],  16'(m_cnt[i]));
        check($sformatf("d%0d.sum8",    i), sm[i],  m_sum[i]);
        check($sformatf("d%0d.done",    i), dn[i],  exp_done);
        check($sformatf("d%0d.cpu_rst", i), crst[i], !exp_done);
        check($sformatf("d%0d.busy",    i), bsy[i], m_started[i] && !exp_done);
        if (we[i] === 1'b1) begin
          if (wn[i] < 64) wlog[i][wn[i]] = ai[i];
          wn[i]      = wn[i] + 1;
          last_we[i] = cyc;
        end
        if (dn[i] === 1'b1 && done_cyc[i] < 0) done_cyc[i] = cyc;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    start   = 1'b0;
    s_valid = 1'b0;
    tick();
    rst = 1'b0;
    clear_logs();
  endtask

  // gap: 0 = continuous, 1 = valid pattern 1,0,0,1, 2 = random gaps.
  // rst_at >= 0 pulses rst (with a byte on offer) once that many bytes have
  // been accepted, then starts again.
  task automatic run_load(input int n_off, input int gap, input bit hold_start,
                          input int rst_at);
    bit did_rst = 1'b0;
    int idx;
    bit v;
    start = 1'b1;
    tick();
    start = hold_start;
    for (int c = 0; c < 60; c++) begin
      if (rst_at >= 0 && !did_rst && m_cnt[0] == rst_at) begin
        did_rst = 1'b1;
        rst     = 1'b1;
        s_valid = 1'b1;
        s_data  = img[m_cnt[0]];
        tick();
        rst     = 1'b0;
        s_valid = 1'b0;
        clear_logs();
        check("rst.cnt",     cn[0],   32'd0);
        check("rst.sum8",    sm[1],   32'd0);
        check("rst.mem_we",  we[0],   32'd0);
        check("rst.s_ready", rdy[0],  32'd0);
        check("rst.cpu_rst", crst[2], 32'd1);
        start = 1'b1;
        tick();
        start = hold_start;
      end
      idx = m_cnt[0];
      unique case (gap)
        0:       v = 1'b1;
        1:       v = (c % 4 == 0) || (c % 4 == 3);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      s_data  = (idx < n_off) ? img[idx] : 8'h00;
      s_valid = (idx < n_off) && v;
      tick();
    end
    s_valid = 1'b0;
    repeat (8) tick();
    check("load.timeout_done", dn[0], 32'd1);
  endtask

  initial begin
    logic [7:0] exp_sum;
    clear_logs();

    // Basic load: bytes 00..0F, continuous valid.
    do_reset();
    check("reset.cpu_rst", crst[0], 32'd1);
    check("reset.busy",    bsy[0],  32'd0);
    for (int k = 0; k < 64; k++) img[k] = 8'(k);
    run_load(16, 0, 1'b0, -1);
    check("basic.sum8",     sm[0],   32'h78);
    check("basic.cnt",      cn[0],   32'd16);
    check("basic.writes",   wn[0],   32'd16);
    check("basic.ai0",      wlog[0][0],  32'h0000);
    check("basic.ai15",     wlog[0][15], 32'h000F);
    check("basic.vi_last",  vi[0],   32'h0F);
    check("basic.latency",  done_cyc[0] - last_we[0], 32'd4);
    check("wait0.latency",  done_cyc[2] - last_we[2], 32'd1);
    check("basic.cpu_rst",  crst[0], 32'd0);

    // Back-pressure gaps 1,0,0,1.
    do_reset();
    run_load(16, 1, 1'b0, -1);
    check("gaps.sum8",   sm[0],       32'h78);
    check("gaps.writes", wn[0],       32'd16);
    check("gaps.ai15",   wlog[0][15], 32'h000F);

    // Overrun: 20 bytes offered.
    do_reset();
    run_load(20, 0, 1'b0, -1);
    check("overrun.cnt",     cn[0],       32'd16);
    check("overrun.writes",  wn[0],       32'd16);
    check("overrun.ai_last", wlog[0][15], 32'h000F);
    check("overrun.s_ready", rdy[0],      32'd0);

    // Mid-load reset after the 7th handshake, then restart.
    do_reset();
    run_load(16, 0, 1'b0, 7);
    check("restart.ai0",    wlog[0][0], 32'h0000);
    check("restart.writes", wn[0],      32'd16);
    check("restart.sum8",   sm[0],      32'h78);

    // Base offset and wrap with 16 bytes of FF.
    do_reset();
    for (int k = 0; k < 64; k++) img[k] = 8'hFF;
    run_load(16, 0, 1'b0, -1);
    check("wrap.sum8", sm[1],       32'hF0);
    check("wrap.ai0",  wlog[1][0],  32'hFFF8);
    check("wrap.ai7",  wlog[1][7],  32'hFFFF);
    check("wrap.ai8",  wlog[1][8],  32'h0000);
    check("wrap.ai15", wlog[1][15], 32'h0007);

    // Stray start held high through LOAD and RUN.
    do_reset();
    for (int k = 0; k < 64; k++) img[k] = 8'(3 * k + 1);
    run_load(16, 0, 1'b1, -1);
    check("stray.latency", done_cyc[2] - last_we[2], 32'd1);
    check("stray.done",    dn[2], 32'd1);
    start = 1'b0;

    // Randomised loads: data, gaps, start holding and mid-load resets.
    for (int r = 0; r < 8; r++) begin
      do_reset();
      exp_sum = 8'h00;
      for (int k = 0; k < 64; k++) img[k] = 8'($urandom_range(0, 255));
      for (int k = 0; k < ROM; k++) exp_sum = exp_sum + img[k];
      run_load(ROM + int'($urandom_range(0, 4)), 2, 1'($urandom_range(0, 1)),
               ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 15)) : -1);
      start = 1'b0;
      check("rand.sum8",   sm[0], 32'(exp_sum));
      check("rand.writes", wn[0], 32'd16);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
